// File: rtl/bool_sweep_checker_if.sv
// Connection bundle between the sweep checker, its controller and the
// 4-input expression unit under check.
interface bool_sweep_checker_if;
    logic        start;
    logic [15:0] exp_table;
    logic        o;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;
    logic        first_fail_vld;
    logic [15:0] obs_table;

    modport slave (
        input  start, exp_table, o,
        output a, b, c, d, busy, done, pass, err_cnt, first_fail,
               first_fail_vld, obs_table
    );

    modport master (
        output start, exp_table, o,
        input  a, b, c, d, busy, done, pass, err_cnt, first_fail,
               first_fail_vld, obs_table
    );
endinterface

// File: rtl/bool_sweep_checker.sv
// Drives all 16 vectors into a 4-input boolean unit, samples its output after
// a settle window and compares against a truth table latched at start.
module bool_sweep_checker #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    bool_sweep_checker_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  v;
    logic [7:0]  settle_cnt;
    logic [15:0] exp_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [4:0]  err_q;
    logic [3:0]  ff_q;
    logic        ffv_q;
    logic [15:0] obs_q;

    logic        go;
    logic        mismatch;
    logic [4:0]  err_nxt;
    logic        settle_end;

    assign go         = ((state == IDLE) || (state == DONE)) && bus.start;
    assign mismatch   = (bus.o != exp_q[v]);
    assign err_nxt    = err_q + {4'd0, mismatch};
    assign settle_end = (settle_cnt == 8'(SETTLE_CYC - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = SETTLE;
            SETTLE:     if (settle_end) state_nxt = SAMPLE;
            SAMPLE:     state_nxt = (v == 4'd15) ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v          <= '0;
            settle_cnt <= '0;
            exp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_q       <= '0;
            ffv_q      <= 1'b0;
            obs_q      <= '0;
        end else if (go) begin
            exp_q      <= bus.exp_table;
            v          <= '0;
            settle_cnt <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_q       <= '0;
            ffv_q      <= 1'b0;
            obs_q      <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 8'd1;
        end else if (state == SAMPLE) begin
            obs_q[v] <= bus.o;
            err_q    <= err_nxt;
            if (mismatch && !ffv_q) begin
                ff_q  <= v;
                ffv_q <= 1'b1;
            end
            // v stays at 15 after the last sample so the drive rests at 1111.
            if (v == 4'd15) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                pass_q <= (err_nxt == 5'd0);
            end else begin
                v          <= v + 4'd1;
                settle_cnt <= '0;
            end
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = v;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ffv_q;
    assign bus.obs_table      = obs_q;

endmodule
